// File: rtl/rr_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types and sizes for the 16-way round-robin arbiter.
// Revision : 1.0  initial release
// ============================================================================
package arb_pkg;
  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [ID_W-1:0]  req_id_t;
endpackage
`default_nettype wire

// File: rtl/rr_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_request_arbiter_if
// Purpose  : Requester-side handshake and grant bus of the round-robin arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface rr_request_arbiter_if;
  import arb_pkg::*;

  logic     ena;
  req_vec_t req;
  logic     release_i;
  logic     gnt_valid;
  req_id_t  gnt_id;
  req_vec_t gnt_onehot;
  req_id_t  ptr;
  logic     timeout;

  modport master (
    output ena, req, release_i,
    input  gnt_valid, gnt_id, gnt_onehot, ptr, timeout
  );

  modport slave (
    input  ena, req, release_i,
    output gnt_valid, gnt_id, gnt_onehot, ptr, timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_request_arbiter_rot_prio_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rot_prio_encoder
// Purpose  : Rotating priority encoder; scans ptr, ptr-1, ... downward with wrap.
// Revision : 1.0  initial release
// ============================================================================
module rot_prio_encoder
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  req_id_t  ptr,
  output logic     hit,
  output req_id_t  winner
);

  req_vec_t w_rot;
  req_id_t  w_top;

  // Rotate so that req[ptr] lands on the top bit and req[ptr+1] on bit 0.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = req[ptr + ID_W'(i + 1)];
    end
  end

  always_comb begin
    w_top = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_rot[i]) begin
        w_top = ID_W'(i);
      end
    end
  end

  assign hit    = |w_rot;
  assign winner = ptr + w_top + ID_W'(1);

endmodule
`default_nettype wire

// File: rtl/rr_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_request_arbiter
// Purpose  : 16-way round-robin arbiter, registered grant, hold-until-release.
//            Optional hold watchdog enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module rr_request_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 8
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  rr_request_arbiter_if.slave  bus
);

  arb_state_t r_state, w_state_nxt;
  logic       r_gnt_valid, w_gnt_valid_nxt;
  req_id_t    r_gnt_id, w_gnt_id_nxt;
  req_vec_t   r_gnt_onehot, w_gnt_onehot_nxt;
  req_id_t    r_ptr, w_ptr_nxt;
  logic       w_hit;
  req_id_t    w_winner;
  logic       w_release;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
`endif

  rot_prio_encoder u_enc (
    .req    (bus.req),
    .ptr    (r_ptr),
    .hit    (w_hit),
    .winner (w_winner)
  );

  // A requester dropping its line is treated exactly like an explicit release.
  assign w_release = bus.release_i || !bus.req[r_gnt_id];

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_valid_nxt  = r_gnt_valid;
    w_gnt_id_nxt     = r_gnt_id;
    w_gnt_onehot_nxt = r_gnt_onehot;
    w_ptr_nxt        = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
    w_timeout_nxt    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt = '0;
`endif
        if (bus.ena && w_hit) begin
          w_state_nxt      = GRANT;
          w_gnt_valid_nxt  = 1'b1;
          w_gnt_id_nxt     = w_winner;
          w_gnt_onehot_nxt = req_vec_t'(1) << w_winner;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt      = IDLE;
          w_gnt_valid_nxt  = 1'b0;
          w_gnt_id_nxt     = '0;
          w_gnt_onehot_nxt = '0;
          w_ptr_nxt        = r_gnt_id - ID_W'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(HOLD_MAX - 1)) begin
          w_state_nxt      = IDLE;
          w_gnt_valid_nxt  = 1'b0;
          w_gnt_id_nxt     = '0;
          w_gnt_onehot_nxt = '0;
          w_ptr_nxt        = r_gnt_id - ID_W'(1);
          w_timeout_nxt    = 1'b1;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_gnt_valid  <= 1'b0;
      r_gnt_id     <= '0;
      r_gnt_onehot <= '0;
      r_ptr        <= ID_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_gnt_valid  <= w_gnt_valid_nxt;
      r_gnt_id     <= w_gnt_id_nxt;
      r_gnt_onehot <= w_gnt_onehot_nxt;
      r_ptr        <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt        <= w_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
`endif
    end
  end

  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_id     = r_gnt_id;
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.ptr        = r_ptr;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout    = r_timeout;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_request_arbiter
// Purpose  : Directed vector bench for the round-robin arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_request_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  rr_request_arbiter_if bus_if ();

`ifdef ARB_TIMEOUT_EN
  rr_request_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );
`else
  rr_request_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [15:0] req;
    logic        rel;
    logic        exp_valid;
    logic [3:0]  exp_id;
    logic [3:0]  exp_ptr;
  } vec_t;

  vec_t vecs [15];
  int   seen [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input logic v, input logic [3:0] id,
                             input logic [3:0] p, input logic to);
    logic [15:0] oh;
    oh = v ? (16'h0001 << id) : 16'h0000;
    chk({tag, " gnt_valid"},  {31'd0, bus_if.gnt_valid}, {31'd0, v});
    chk({tag, " gnt_id"},     {28'd0, bus_if.gnt_id},    {28'd0, (v ? id : 4'd0)});
    chk({tag, " gnt_onehot"}, {16'd0, bus_if.gnt_onehot}, {16'd0, oh});
    chk({tag, " ptr"},        {28'd0, bus_if.ptr},       {28'd0, p});
    chk({tag, " timeout"},    {31'd0, bus_if.timeout},   {31'd0, to});
  endtask

  initial begin
    logic ok;
    n_chk  = 0;
    n_pass = 0;

    //            ena   req       rel   valid id     ptr
    vecs[0]  = '{1'b1, 16'h8001, 1'b0, 1'b1, 4'd15, 4'd15};
    vecs[1]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 4'd0,  4'd14};
    vecs[2]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 4'd0,  4'd14};
    vecs[3]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 4'd0,  4'd15};
    vecs[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  4'd15};
    vecs[5]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 4'd0,  4'd15};
    vecs[6]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 4'd0,  4'd15};
    vecs[7]  = '{1'b1, 16'h0010, 1'b0, 1'b1, 4'd4,  4'd15};
    vecs[8]  = '{1'b0, 16'h0010, 1'b0, 1'b1, 4'd4,  4'd15};
    vecs[9]  = '{1'b1, 16'h0210, 1'b1, 1'b0, 4'd0,  4'd3};
    vecs[10] = '{1'b1, 16'h0200, 1'b0, 1'b1, 4'd9,  4'd3};
    vecs[11] = '{1'b1, 16'h0201, 1'b0, 1'b1, 4'd9,  4'd3};
    vecs[12] = '{1'b1, 16'h0001, 1'b0, 1'b0, 4'd0,  4'd8};
    vecs[13] = '{1'b1, 16'h0001, 1'b0, 1'b1, 4'd0,  4'd8};
    vecs[14] = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  4'd15};

    bus_if.ena       = 1'b0;
    bus_if.req       = 16'h0000;
    bus_if.release_i = 1'b0;
    rst_n            = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_outputs("reset", 1'b0, 4'd0, 4'd15, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_outputs("post_reset_idle", 1'b0, 4'd0, 4'd15, 1'b0);

    // Priority, edge cases, simultaneous release + new request
    for (int i = 0; i < 15; i++) begin
      bus_if.ena       = vecs[i].ena;
      bus_if.req       = vecs[i].req;
      bus_if.release_i = vecs[i].rel;
      step();
      chk_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id,
                  vecs[i].exp_ptr, 1'b0);
    end
    bus_if.release_i = 1'b0;

    // Fairness: all requesting, one release per grant
    for (int k = 0; k < 16; k++) seen[k] = 0;
    bus_if.ena = 1'b1;
    bus_if.req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      logic [3:0] exp_id;
      exp_id = 4'(15 - k);
      step();
      chk($sformatf("fair%0d gnt_valid", k), {31'd0, bus_if.gnt_valid}, 32'd1);
      chk($sformatf("fair%0d gnt_id", k), {28'd0, bus_if.gnt_id}, {28'd0, exp_id});
      if (k < 16) begin
        seen[bus_if.gnt_id]++;
        bus_if.release_i = 1'b1;
        step();
        chk($sformatf("fair%0d idle", k), {31'd0, bus_if.gnt_valid}, 32'd0);
        bus_if.release_i = 1'b0;
      end
    end
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fair_count id%0d", k), seen[k], 32'd1);
    end

    // Asynchronous reset while granting, no clock edge needed
    #2 rst_n = 1'b0;
    #1;
    chk_outputs("async_reset", 1'b0, 4'd0, 4'd15, 1'b0);
    bus_if.req = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_outputs("after_async_reset", 1'b0, 4'd0, 4'd15, 1'b0);

    // Watchdog / indefinite hold
    bus_if.req = 16'h0004;
    step();
    chk_outputs("hold_grant", 1'b1, 4'd2, 4'd15, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int j = 1; j < 4; j++) begin
      step();
      chk_outputs($sformatf("wd_hold%0d", j), 1'b1, 4'd2, 4'd15, 1'b0);
    end
    step();
    chk_outputs("wd_revoke", 1'b0, 4'd0, 4'd1, 1'b1);
    step();
    chk_outputs("wd_regrant", 1'b1, 4'd2, 4'd1, 1'b0);
    bus_if.req = 16'h0000;
    step();
    chk_outputs("wd_release", 1'b0, 4'd0, 4'd1, 1'b0);
`else
    ok = 1'b1;
    for (int j = 0; j < 100; j++) begin
      step();
      if (!(bus_if.gnt_valid === 1'b1 && bus_if.gnt_id === 4'd2 && bus_if.timeout === 1'b0))
        ok = 1'b0;
    end
    chk("hold_100_cycles", {31'd0, ok}, 32'd1);
    bus_if.req = 16'h0000;
    step();
    chk_outputs("hold_release", 1'b0, 4'd0, 4'd1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
